// File: rtl/csr_access_master.sv
// CSR bus initiator: one host access at a time, spread over decode / execute / collect, OR-combined response.
// Latency: accept edge -> ADDR, EXEC, COLLECT, then RESP (1 access per 5 cycles min); response held until resp_ready, req_ready only in IDLE.
module csr_access_master #(
  parameter int          NSLV      = 4,
  parameter logic [11:0] IDLE_ADDR = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [11:0]       req_addr,
  input  logic              req_read,
  input  logic [2:0]        req_modify,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [11:0]       csr_addr,
  output logic              csr_read,
  output logic [2:0]        csr_modify,
  output logic [31:0]       csr_wdata,
  input  logic [NSLV-1:0]   csr_valid,
  input  logic [32*NSLV-1:0] csr_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_EXEC    = 3'd2,
    S_COLLECT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [11:0] lat_addr;
  logic        lat_read;
  logic [2:0]  lat_mod;
  logic [31:0] lat_wdata;
  logic        lat_ro;

  logic        req_is_wr;
  logic        req_ro;
  logic [2:0]  req_eff_mod;

  logic        hit_any;
  logic        hit_multi;
  logic [31:0] col_rdata;
  logic [1:0]  col_err;
  logic [31:0] col_rdata_ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = S_ADDR;
      S_ADDR:    state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_COLLECT;
      S_COLLECT: state_nxt = S_RESP;
      S_RESP:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Writes into the 2'b11 address quadrant are suppressed on the bus but still read back.
  always_comb begin
    req_is_wr   = (req_modify == 3'b001) || (req_modify == 3'b010) || (req_modify == 3'b011);
    req_ro      = req_is_wr && (req_addr[11:10] == 2'b11);
    req_eff_mod = (req_is_wr && !req_ro) ? req_modify : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= 12'h000;
      lat_read  <= 1'b0;
      lat_mod   <= 3'b000;
      lat_wdata <= 32'h0;
      lat_ro    <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      lat_addr  <= req_addr;
      lat_read  <= req_read;
      lat_mod   <= req_eff_mod;
      lat_wdata <= req_wdata;
      lat_ro    <= req_ro;
    end
  end

  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    col_rdata = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      hit_multi = hit_multi | (hit_any & csr_valid[i]);
      hit_any   = hit_any | csr_valid[i];
      col_rdata = col_rdata | csr_rdata[32*i +: 32];
    end
    col_rdata_ret = (hit_any && !hit_multi) ? col_rdata : 32'h0;
    if (lat_ro)         col_err = 2'b11;
    else if (hit_multi) col_err = 2'b10;
    else if (!hit_any)  col_err = 2'b01;
    else                col_err = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= 32'h0;
      resp_err   <= 2'b00;
    end else if (state == S_COLLECT) begin
      resp_rdata <= col_rdata_ret;
      resp_err   <= col_err;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    csr_addr   = IDLE_ADDR;
    csr_read   = 1'b0;
    csr_modify = 3'b000;
    csr_wdata  = 32'h0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_ADDR: csr_addr = lat_addr;
      S_EXEC: begin
        csr_read   = lat_read;
        csr_modify = lat_mod;
        csr_wdata  = lat_wdata;
      end
      S_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_master.sv
// Directed bench for csr_access_master: vector table of single accesses plus backpressure and reset-in-ADDR sequences.
module tb_csr_access_master;

  localparam int NSLV = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [11:0]       req_addr;
  logic              req_read;
  logic [2:0]        req_modify;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;
  logic [11:0]       csr_addr;
  logic              csr_read;
  logic [2:0]        csr_modify;
  logic [31:0]       csr_wdata;
  logic [NSLV-1:0]   csr_valid;
  logic [32*NSLV-1:0] csr_rdata;

  int errors = 0;
  int checks = 0;
  int bus_writes = 0;

  csr_access_master #(.NSLV(NSLV), .IDLE_ADDR(12'h000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_read(req_read), .req_modify(req_modify), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .csr_addr(csr_addr), .csr_read(csr_read), .csr_modify(csr_modify),
    .csr_wdata(csr_wdata), .csr_valid(csr_valid), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  // Responder-side view: any nonzero modify seen on the bus counts as a write.
  always @(negedge clk) if (csr_modify != 3'b000) bus_writes++;

  typedef struct {
    logic [11:0]  addr;
    logic         rd;
    logic [2:0]   mod;
    logic [31:0]  wdata;
    logic [3:0]   vld;
    logic [127:0] rdata;
    logic [2:0]   exp_mod;
    logic [1:0]   exp_err;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input int hold);
    int w0;
    @(negedge clk);
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    req_read   = v.rd;
    req_modify = v.mod;
    req_wdata  = v.wdata;
    w0 = bus_writes;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 12'hFFF;
    req_read   = 1'b0;
    req_modify = 3'b111;
    req_wdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("addr_csr_addr", {20'b0, csr_addr}, {20'b0, v.addr});
    chk("addr_csr_modify", {29'b0, csr_modify}, 32'd0);
    chk("addr_csr_read", {31'b0, csr_read}, 32'd0);
    chk("addr_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("exec_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("exec_csr_modify", {29'b0, csr_modify}, {29'b0, v.exp_mod});
    chk("exec_csr_read", {31'b0, csr_read}, {31'b0, v.rd});
    chk("exec_csr_wdata", csr_wdata, v.wdata);
    csr_valid = v.vld;
    csr_rdata = v.rdata;
    @(negedge clk);
    chk("coll_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("coll_csr_modify", {29'b0, csr_modify}, 32'd0);
    chk("coll_csr_read", {31'b0, csr_read}, 32'd0);
    chk("coll_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    csr_valid = '0;
    csr_rdata = '0;
    @(negedge clk);
    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("resp_err", {30'b0, resp_err}, {30'b0, v.exp_err});
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_addr  = 12'hAAA;
      @(negedge clk);
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_resp_rdata", resp_rdata, v.exp_rdata);
      chk("hold_resp_err", {30'b0, resp_err}, {30'b0, v.exp_err});
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_csr_addr", {20'b0, csr_addr}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("done_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("done_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bus_write_count", bus_writes - w0, (v.exp_mod != 3'b000) ? 32'd1 : 32'd0);
  endtask

  initial begin
    vec_t hv;
    int   w0;

    // addr, rd, mod, wdata, vld, rdata{s3,s2,s1,s0}, exp_mod, exp_err, exp_rdata
    vecs[0] = '{12'hF14, 1'b1, 3'b000, 32'h0,  4'b0001, {32'h0, 32'h0, 32'h0, 32'h3},    3'b000, 2'b00, 32'h3};
    vecs[1] = '{12'hBC1, 1'b0, 3'b001, 32'h5,  4'b0010, {32'h0, 32'h0, 32'h0, 32'h0},    3'b001, 2'b00, 32'h0};
    vecs[2] = '{12'hF11, 1'b1, 3'b010, 32'hFF, 4'b0100, {32'h0, 32'hABCD, 32'h0, 32'h0}, 3'b000, 2'b11, 32'hABCD};
    vecs[3] = '{12'h123, 1'b1, 3'b000, 32'h0,  4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},    3'b000, 2'b01, 32'h0};
    vecs[4] = '{12'h123, 1'b1, 3'b000, 32'h0,  4'b0011, {32'h0, 32'h0, 32'h2, 32'h1},    3'b000, 2'b10, 32'h0};
    vecs[5] = '{12'h200, 1'b0, 3'b011, 32'hF0, 4'b1000, {32'h77, 32'h0, 32'h0, 32'h0},   3'b011, 2'b00, 32'h77};
    vecs[6] = '{12'h300, 1'b1, 3'b100, 32'h12, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h9},    3'b000, 2'b00, 32'h9};
    vecs[7] = '{12'hC00, 1'b0, 3'b001, 32'h1,  4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},    3'b000, 2'b11, 32'h0};
    vecs[8] = '{12'hFFF, 1'b1, 3'b011, 32'h3,  4'b1001, {32'h5, 32'h0, 32'h0, 32'h6},    3'b000, 2'b11, 32'h0};
    vecs[9] = '{12'h7FF, 1'b1, 3'b010, 32'hA5, 4'b0010, {32'h0, 32'h0, 32'h8000_0001, 32'h0}, 3'b010, 2'b00, 32'h8000_0001};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_read   = 1'b0;
    req_modify = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    csr_valid  = '0;
    csr_rdata  = '0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {30'b0, resp_err}, 32'd0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_csr_modify", {29'b0, csr_modify}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(vecs[i], 0);

    // Backpressure: response held for 10 cycles, then back-to-back request.
    do_txn(vecs[0], 10);
    do_txn(vecs[5], 0);

    // Reset during the ADDR cycle of a write.
    hv = vecs[1];
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 12'hBC2;
    req_read   = 1'b0;
    req_modify = 3'b001;
    req_wdata  = 32'h1234;
    w0 = bus_writes;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_rst_csr_addr", {20'b0, csr_addr}, 32'h0000_0BC2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("arst_resp_rdata", resp_rdata, 32'd0);
    chk("arst_resp_err", {30'b0, resp_err}, 32'd0);
    chk("arst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("arst_csr_read", {31'b0, csr_read}, 32'd0);
    chk("arst_csr_modify", {29'b0, csr_modify}, 32'd0);
    chk("arst_csr_wdata", csr_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_rst_no_write", bus_writes - w0, 32'd0);

    // Normal operation resumes after the aborted access.
    do_txn(hv, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
